// File: rtl/pool_1_sched.sv
// ---------------------------------------------------------------------------
// pool_1_sched
//
// Read sequencer for the pool_1 layer. Walks the conv_2d feature-map buffer in
// non-overlapping POOL x POOL windows (stride POOL) and issues one buffer read
// per cycle. Each read carries window-boundary markers for the max-compare
// datapath. The block also generates the output write strobe and address, and
// gives the buffer port to the conv_2d writer whenever that writer is active.
//
// Build option:
//   POOL_1_SCHED_ODD_PAD_EN  when defined, partial edge windows are processed
//                            (ceil(IMG/POOL) windows per axis). Only their
//                            in-range elements are read. When undefined, the
//                            leftover rows and columns are skipped.
//
// Ports:
//   clk                  clock, rising edge
//   rst                  asynchronous reset, active-high
//   pool_1_layer_enable  level start request (sampled in IDLE only)
//   conv_2d_wr_en        conv_2d writer owns the buffer port (stalls reads)
//   pool_1_rd_en         buffer read strobe
//   pool_1_rd_addr       buffer read address, row-major
//   anchor_height        top-left row of the window being read
//   anchor_width         top-left column of the window being read
//   win_first            first element of a window (qualified by rd_en)
//   win_last             last element of a window (qualified by rd_en)
//   pool_1_out_wr_en     comparator result valid, write it
//   pool_1_out_addr      output address, row-major
//   busy                 high in RUN and DRAIN
//   done                 one-cycle pulse at the end of a run
// ---------------------------------------------------------------------------
module pool_1_sched #(
    parameter int IMG_W  = 35,
    parameter int IMG_H  = 35,
    parameter int POOL   = 2,
    parameter int RD_LAT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pool_1_layer_enable,
    input  logic        conv_2d_wr_en,
    output logic        pool_1_rd_en,
    output logic [15:0] pool_1_rd_addr,
    output logic [15:0] anchor_height,
    output logic [15:0] anchor_width,
    output logic        win_first,
    output logic        win_last,
    output logic        pool_1_out_wr_en,
    output logic [15:0] pool_1_out_addr,
    output logic        busy,
    output logic        done
);

`ifdef POOL_1_SCHED_ODD_PAD_EN
    localparam int NWX = (IMG_W + POOL - 1) / POOL;
    localparam int NWY = (IMG_H + POOL - 1) / POOL;
`else
    localparam int NWX = IMG_W / POOL;
    localparam int NWY = IMG_H / POOL;
`endif

    localparam logic [15:0] LAST_AW = 16'((NWX - 1) * POOL);
    localparam logic [15:0] LAST_AH = 16'((NWY - 1) * POOL);
    localparam logic [15:0] POOL16  = 16'(POOL);
    localparam logic [15:0] IMG_W16 = 16'(IMG_W);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, HOLD} state_t;

    state_t             state;
    logic [15:0]        ah, aw;     // current window anchor
    logic [15:0]        dy, dx;     // element offset inside the window
    logic [RD_LAT-1:0]  dly;        // win_last strobes in flight through the buffer

    logic [15:0] win_w, win_h;
    logic [15:0] rd_row, rd_col, addr_next;
    logic        x_end, y_end, last_win, pending;

    // Effective window size: full POOL, or clipped at the right/bottom edge
    // when partial windows are enabled.
`ifdef POOL_1_SCHED_ODD_PAD_EN
    logic [15:0] rem_w, rem_h;
    always_comb begin
        rem_w = IMG_W16 - aw;
        rem_h = 16'(IMG_H) - ah;
        win_w = (rem_w < POOL16) ? rem_w : POOL16;
        win_h = (rem_h < POOL16) ? rem_h : POOL16;
    end
`else
    always_comb begin
        win_w = POOL16;
        win_h = POOL16;
    end
`endif

    always_comb begin
        rd_row    = ah + dy;
        rd_col    = aw + dx;
        addr_next = rd_row * IMG_W16 + rd_col;   // truncated to 16 bits
        x_end     = (dx == win_w - 16'd1);
        y_end     = (dy == win_h - 16'd1);
        last_win  = (aw == LAST_AW) && (ah == LAST_AH);
        // A window-closing read still on the bus or inside the delay line.
        pending   = (pool_1_rd_en & win_last) | (|dly);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state            <= IDLE;
            ah               <= '0;
            aw               <= '0;
            dy               <= '0;
            dx               <= '0;
            dly              <= '0;
            pool_1_rd_en     <= 1'b0;
            pool_1_rd_addr   <= '0;
            anchor_height    <= '0;
            anchor_width     <= '0;
            win_first        <= 1'b0;
            win_last         <= 1'b0;
            pool_1_out_wr_en <= 1'b0;
            pool_1_out_addr  <= '0;
            busy             <= 1'b0;
            done             <= 1'b0;
        end else begin
            pool_1_rd_en <= 1'b0;
            win_first    <= 1'b0;
            win_last     <= 1'b0;
            done         <= 1'b0;

            // Output strobe delay line; runs regardless of stalls so reads
            // already issued always produce their write.
            dly[0] <= pool_1_rd_en & win_last;
            for (int i = 1; i < RD_LAT; i++) begin
                dly[i] <= dly[i-1];
            end
            pool_1_out_wr_en <= dly[RD_LAT-1];
            if (pool_1_out_wr_en) begin
                pool_1_out_addr <= pool_1_out_addr + 16'd1;
            end

            case (state)
                IDLE: begin
                    if (pool_1_layer_enable) begin
                        state           <= RUN;
                        busy            <= 1'b1;
                        ah              <= '0;
                        aw              <= '0;
                        dy              <= '0;
                        dx              <= '0;
                        pool_1_out_addr <= '0;
                    end
                end
                RUN: begin
                    if (!conv_2d_wr_en) begin
                        pool_1_rd_en   <= 1'b1;
                        pool_1_rd_addr <= addr_next;
                        anchor_height  <= ah;
                        anchor_width   <= aw;
                        win_first      <= (dx == 16'd0) && (dy == 16'd0);
                        win_last       <= x_end && y_end;
                        // dy-major inside a window, windows column-first.
                        if (!x_end) begin
                            dx <= dx + 16'd1;
                        end else begin
                            dx <= '0;
                            if (!y_end) begin
                                dy <= dy + 16'd1;
                            end else begin
                                dy <= '0;
                                if (aw != LAST_AW) begin
                                    aw <= aw + POOL16;
                                end else begin
                                    aw <= '0;
                                    if (ah != LAST_AH) begin
                                        ah <= ah + POOL16;
                                    end
                                end
                                if (last_win) begin
                                    state <= DRAIN;
                                end
                            end
                        end
                    end
                end
                DRAIN: begin
                    if (!pending) begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= HOLD;
                    end
                end
                HOLD: begin
                    // A level held high must not retrigger the run.
                    if (!pool_1_layer_enable) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pool_1_sched.sv
module tb_pool_1_sched;

`ifdef POOL_1_SCHED_ODD_PAD_EN
    localparam int NR = 1225;
    localparam int NW = 324;
`else
    localparam int NR = 1156;
    localparam int NW = 289;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        cwr;
    logic        rd_en;
    logic [15:0] rd_addr;
    logic [15:0] anc_h;
    logic [15:0] anc_w;
    logic        wf;
    logic        wl;
    logic        out_we;
    logic [15:0] out_addr;
    logic        busy;
    logic        done;

    pool_1_sched dut (
        .clk                 (clk),
        .rst                 (rst),
        .pool_1_layer_enable (en),
        .conv_2d_wr_en       (cwr),
        .pool_1_rd_en        (rd_en),
        .pool_1_rd_addr      (rd_addr),
        .anchor_height       (anc_h),
        .anchor_width        (anc_w),
        .win_first           (wf),
        .win_last            (wl),
        .pool_1_out_wr_en    (out_we),
        .pool_1_out_addr     (out_addr),
        .busy                (busy),
        .done                (done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    int rd_a_q[$];
    int rd_c_q[$];
    int rd_f_q[$];
    int rd_l_q[$];
    int wr_a_q[$];
    int wr_c_q[$];
    int dn_c_q[$];

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Event recorder, sampled on the falling edge.
    initial begin
        forever begin
            @(negedge clk);
            if (rd_en) begin
                rd_a_q.push_back(int'(rd_addr));
                rd_c_q.push_back(cyc);
                rd_f_q.push_back(int'(wf));
                rd_l_q.push_back(int'(wl));
            end
            if (out_we) begin
                wr_a_q.push_back(int'(out_addr));
                wr_c_q.push_back(cyc);
            end
            if (done) dn_c_q.push_back(cyc);
        end
    end

    task automatic clear_logs();
        rd_a_q.delete(); rd_c_q.delete(); rd_f_q.delete(); rd_l_q.delete();
        wr_a_q.delete(); wr_c_q.delete(); dn_c_q.delete();
    endtask

    task automatic start_run(output int c);
        @(negedge clk);
        #1;
        clear_logs();
        c  = cyc;
        en = 1'b1;
    endtask

    task automatic wait_done(input int budget);
        int k;
        for (k = 0; k < budget; k++) begin
            @(negedge clk);
            #1;
            if (dn_c_q.size() > 0) break;
        end
        if (k >= budget) chk("done_timeout", 0, 1);
    endtask

    int c1, c2, c3, c4, t1;
    bit hit;

    initial begin
        rst = 1'b1; en = 1'b0; cwr = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_rd_en", int'(rd_en), 0);
        chk("rst_outputs", int'(rd_addr | anc_h | anc_w | out_addr), 0);
        chk("rst_flags", int'({wf, wl, out_we, busy, done}), 0);
        @(negedge clk);
        rst = 1'b0;

        // ---- run 1: basic start and full run without stalls ----
        start_run(c1);
        repeat (3) @(negedge clk);
        #1;
        chk("busy_run", int'(busy), 1);
        wait_done(3000);
        chk("read_count", rd_a_q.size(), NR);
        chk("write_count", wr_a_q.size(), NW);
        if (rd_a_q.size() == NR && wr_a_q.size() == NW) begin
            chk("first_read_latency", rd_c_q[0] - c1, 2);
            chk("rd0", rd_a_q[0], 0);
            chk("rd1", rd_a_q[1], 1);
            chk("rd2", rd_a_q[2], 35);
            chk("rd3", rd_a_q[3], 36);
            chk("first_flags", rd_f_q[0] * 2 + rd_l_q[0], 2);
            chk("last_flags", rd_f_q[3] * 2 + rd_l_q[3], 1);
            chk("wr0_addr", wr_a_q[0], 0);
            chk("wr0_latency", wr_c_q[0] - rd_c_q[3], 2);
            chk("reads_contiguous", rd_c_q[NR-1] - rd_c_q[0], NR - 1);
`ifdef POOL_1_SCHED_ODD_PAD_EN
            chk("pad_rd_0_34_a", rd_a_q[68], 34);
            chk("pad_rd_0_34_b", rd_a_q[69], 69);
            chk("pad_rd_0_34_last", rd_l_q[69], 1);
            chk("pad_rd_corner", rd_a_q[NR-1], 1224);
            chk("pad_corner_flags", rd_f_q[NR-1] * 2 + rd_l_q[NR-1], 3);
`else
            chk("last_win_rd0", rd_a_q[NR-4], 1152);
            chk("last_win_rd1", rd_a_q[NR-3], 1153);
            chk("last_win_rd2", rd_a_q[NR-2], 1187);
            chk("last_win_rd3", rd_a_q[NR-1], 1188);
`endif
            chk("last_wr_addr", wr_a_q[NW-1], NW - 1);
            chk("last_wr_latency", wr_c_q[NW-1] - rd_c_q[NR-1], 2);
        end
        if (dn_c_q.size() > 0 && wr_c_q.size() > 0) begin
            chk("done_after_last_wr", dn_c_q[0] - wr_c_q[wr_c_q.size()-1], 1);
            chk("run_length", dn_c_q[0] - c1, NR + 4);
        end

        // enable held high: no second run
        repeat (30) @(negedge clk);
        #1;
        chk("hold_no_rerun", rd_a_q.size(), NR);
        chk("hold_done_once", dn_c_q.size(), 1);
        chk("hold_busy", int'(busy), 0);

        // ---- run 2: restart with a 5-cycle stall after the read of 1 ----
        en = 1'b0;
        repeat (3) @(negedge clk);
        start_run(c2);
        hit = 1'b0;
        for (int k = 0; k < 20 && !hit; k++) begin
            @(negedge clk);
            #1;
            if (rd_en && rd_addr == 16'd1) hit = 1'b1;
        end
        chk("stall_trigger_seen", int'(hit), 1);
        cwr = 1'b1;
        repeat (5) @(negedge clk);
        #1;
        cwr = 1'b0;
        wait_done(3000);
        chk("restart_read_count", rd_a_q.size(), NR);
        if (rd_a_q.size() >= 3 && wr_a_q.size() > 0) begin
            chk("restart_rd0", rd_a_q[0], 0);
            chk("restart_wr0_addr", wr_a_q[0], 0);
            chk("stall_resume_addr", rd_a_q[2], 35);
            chk("stall_gap", rd_c_q[2] - rd_c_q[1], 6);
        end
        if (dn_c_q.size() > 0) chk("stall_run_length", dn_c_q[0] - c2, NR + 4 + 5);

        // ---- run 3: reset in the middle of a run ----
        en = 1'b0;
        repeat (3) @(negedge clk);
        start_run(c3);
        hit = 1'b0;
        for (int k = 0; k < 20 && !hit; k++) begin
            @(negedge clk);
            #1;
            if (rd_en && wl) hit = 1'b1;
        end
        chk("win_last_seen", int'(hit), 1);
        rst = 1'b1;
        en  = 1'b0;
        #1;
        chk("midrst_rd_en", int'(rd_en), 0);
        chk("midrst_outputs", int'(rd_addr | anc_h | anc_w | out_addr), 0);
        chk("midrst_flags", int'({wf, wl, out_we, busy, done}), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        t1 = wr_a_q.size();
        repeat (6) @(negedge clk);
        #1;
        chk("midrst_no_pending_wr", wr_a_q.size(), t1);
        chk("midrst_idle_no_reads", int'(busy), 0);

        start_run(c4);
        wait_done(3000);
        chk("post_rst_read_count", rd_a_q.size(), NR);
        if (rd_a_q.size() > 0 && wr_a_q.size() > 0) begin
            chk("post_rst_rd0", rd_a_q[0], 0);
            chk("post_rst_wr0", wr_a_q[0], 0);
        end
        chk("post_rst_write_count", wr_a_q.size(), NW);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pool_1_sched.md
# pool_1_sched

Read sequencer for the pool_1 layer. It walks the conv_2d feature-map buffer in non-overlapping POOL×POOL windows and issues one buffer read per cycle, with window-boundary markers for the max-compare datapath. It also generates the output write strobe and address, and yields the buffer port to the conv_2d writer whenever that writer is active. The block sits between the conv_2d output buffer and the pool_1 comparator, and is started by `pool_1_layer_enable`.

## Interface
- `IMG_W`, 35: feature-map width in pixels.
- `IMG_H`, 35: feature-map height in pixels.
- `POOL`, 2: window edge length; the stride equals POOL.
- `RD_LAT`, 1: buffer read latency in cycles.
- `clk` in 1: clock, rising edge.
- `rst` in 1: asynchronous reset, active-high.
- `pool_1_layer_enable` in 1: level start request.
- `conv_2d_wr_en` in 1: conv_2d writer owns the buffer port; this has priority.
- `pool_1_rd_en` out 1: buffer read strobe.
- `pool_1_rd_addr` out 16: buffer read address, row-major.
- `anchor_height` out 16: top-left row of the current window.
- `anchor_width` out 16: top-left column of the current window.
- `win_first` out 1: qualifies `pool_1_rd_en`; marks the first element of a window.
- `win_last` out 1: qualifies `pool_1_rd_en`; marks the last element of a window.
- `pool_1_out_wr_en` out 1: comparator result is valid; write it.
- `pool_1_out_addr` out 16: output address, row-major.
- `busy` out 1: high in RUN and DRAIN.
- `done` out 1: one-cycle pulse at the end of a run.

## Operation
- **States:** IDLE, RUN, DRAIN, HOLD.
- **IDLE:**
  - Enters RUN when `pool_1_layer_enable`=1 is sampled.
  - On entry, the window counters, element counters and `pool_1_out_addr` are cleared.
- **RUN:**
  - One read per unstalled cycle.
  - Element order within a window: dy-major, then dx, i.e. (0,0),(0,1),(1,0),(1,1) for POOL=2.
  - Address: `pool_1_rd_addr` = (anchor_height+dy)*IMG_W + (anchor_width+dx), truncated to 16 bits.
  - Window order: windows advance column-first, then row.
  - Window count without padding: floor(IMG_W/POOL) × floor(IMG_H/POOL) = 17×17 = 289 at the defaults.
  - Leftover rows and columns (row/col 34 at the defaults) are skipped.
  - After the last read, RUN goes to DRAIN.
- **Stall:**
  - While `conv_2d_wr_en`=1, `pool_1_rd_en`, `win_first` and `win_last` are 0.
  - All counters and addresses hold.
  - Reads already in flight still complete and produce their `pool_1_out_wr_en`.
- **Output strobe:**
  - `pool_1_out_wr_en` pulses RD_LAT+1 cycles after each read cycle that has `win_last`=1.
  - Implemented as a delay line; the strobe is never suppressed by a stall.
  - `pool_1_out_addr` increments the cycle after each `pool_1_out_wr_en`.
- **DRAIN:**
  - Waits until the delay line is empty.
  - Then pulses `done` for one cycle and moves to HOLD.
- **HOLD:** returns to IDLE when `pool_1_layer_enable`=0. A level that stays high does not restart the block.
- **Enable deassert:** dropping `pool_1_layer_enable` during RUN or DRAIN is ignored; the run completes. Only `rst` aborts a run.

## Timing
- **Reset values:**
  - All outputs are 0, and the state is IDLE.
  - `rst` clears everything asynchronously, including the delay line and any pending strobes.
- **Start latency:** enable sampled at edge N gives the first `pool_1_rd_en` valid after edge N+1.
- **Run length without stalls:**
  - 1156 read cycles, contiguous at the defaults.
  - The last `pool_1_out_wr_en` comes RD_LAT+1 cycles after the last read.
  - `done` comes in the cycle after the last `pool_1_out_wr_en`.
- **Stalls:** each cycle with `conv_2d_wr_en`=1 during RUN adds exactly one cycle.
- **Concurrent window flags:** `win_first` and `win_last` are both 1 only for 1-element windows; this occurs only with padding.
- **Output registers:** all outputs are registered.

## Configuration
- **`POOL_1_SCHED_ODD_PAD_EN` defined:**
  - Partial edge windows are processed: ceil(IMG/POOL) windows per axis, 18×18 = 324 at the defaults.
  - Edge windows read only the in-range elements (2×1, 1×2 or 1×1), and `win_last` marks the last valid element.
  - Total reads: 1225.
- **Undefined:** floor behaviour as specified under Operation.

## Test plan
- **Basic start:** raise enable.
  - Reads 0, 1, 35, 36; `win_first` on 0 and `win_last` on 36.
  - `pool_1_out_wr_en` with `pool_1_out_addr`=0 two cycles after the read of 36.
- **Full run, no stalls:**
  - Last window at anchor (32,32) reads 1152, 1153, 1187, 1188.
  - Final `pool_1_out_addr`=288; 1156 read cycles; one `done` pulse.
- **Stall:** `conv_2d_wr_en`=1 for 5 cycles after the read of 1.
  - `pool_1_rd_en`=0 for those 5 cycles; address resumes at 35.
  - `done` is 5 cycles later than in the no-stall run.
- **Restart:** hold enable through `done`.
  - No second run while enable stays high.
  - Drop and re-raise enable: new run from read 0 and `pool_1_out_addr` 0.
- **Reset mid-run:** assert `rst` during RUN.
  - All outputs are 0 immediately, with no pending `pool_1_out_wr_en`.
  - After release, an enable restarts from address 0.
- **With `POOL_1_SCHED_ODD_PAD_EN`:**
  - Window (0,34) reads 34, 69.
  - Window (34,34) reads 1224 with `win_first`=`win_last`=1.
  - 324 output writes.
